// File: rtl/stage_status_responder.sv
// Stage-side responder for the controller status interface.
// Three fixed-latency stage sequencers (M, C, D) each follow the sampled
// controller state and report IDLE/BUSY/DONE/FAULT on MS, CS and DS.

// One stage: IDLE -> BUSY for N clocks -> DONE, with sticky FAULT.
module stage_fsm #(
    parameter logic [1:0]  PHASE = 2'b01,
    parameter int unsigned N     = 3,
    parameter int unsigned CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] state,
    input  logic       fault,
    output logic [1:0] status,
    output logic       to_done
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_BUSY  = 2'b01,
        S_DONE  = 2'b10,
        S_FAULT = 2'b11
    } st_e;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    st_e              st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and counter registers; reset aborts any work in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= S_IDLE;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    // Next-state: controller IDLE beats fault, fault beats abort, abort beats completion.
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        to_done = 1'b0;
        case (st_q)
            S_IDLE: begin
                if (state == PHASE) begin
                    st_d  = S_BUSY;
                    cnt_d = '0;
                end
            end
            S_BUSY: begin
                if (state == 2'b00) begin
                    st_d  = S_IDLE;
                    cnt_d = '0;
                end else if (fault) begin
                    st_d = S_FAULT;
                end else if (state != PHASE) begin
                    st_d  = S_IDLE;
                    cnt_d = '0;
                end else if (cnt_q == LAST) begin
                    // Counter parks at N-1; it never wraps.
                    st_d    = S_DONE;
                    to_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                // Faults are not observed once the work has completed.
                if (state != PHASE) begin
                    st_d  = S_IDLE;
                    cnt_d = '0;
                end
            end
            S_FAULT: begin
                // Sticky until the controller returns to IDLE.
                if (state == 2'b00) begin
                    st_d  = S_IDLE;
                    cnt_d = '0;
                end
            end
            default: st_d = S_IDLE;
        endcase
    end

    assign status = st_q;
endmodule

// Top: three stage sequencers plus the shared done pulse and busy summary.
module stage_status_responder #(
    parameter int unsigned M_CYCLES = 3,
    parameter int unsigned C_CYCLES = 6,
    parameter int unsigned D_CYCLES = 2,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] state,
    input  logic [2:0] fault_in,
    output logic [1:0] MS,
    output logic [1:0] CS,
    output logic [1:0] DS,
    output logic       done_pulse,
    output logic       any_busy
);
    localparam int NUM_STAGES = 3;

    logic [NUM_STAGES-1:0][1:0] status;
    logic [NUM_STAGES-1:0]      to_done;
    logic                       done_evt_q, done_evt_d;
    logic                       done_pulse_q, done_pulse_d;

    // Stage g answers to phase code g+1 (M=01, C=10, D=11).
    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        localparam int unsigned N = (g == 0) ? M_CYCLES :
                                    (g == 1) ? C_CYCLES : D_CYCLES;
        stage_fsm #(
            .PHASE (2'(g + 1)),
            .N     (N),
            .CNT_W (CNT_W)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .state   (state),
            .fault   (fault_in[g]),
            .status  (status[g]),
            .to_done (to_done[g])
        );
    end

    // The BUSY->DONE edge is captured once, then replayed as the pulse a
    // clock later, so the pulse lands on the cycle after DONE is first shown.
    always_comb begin
        done_evt_d   = |to_done;
        done_pulse_d = done_evt_q;
    end

    // Done-pulse pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_evt_q   <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            done_evt_q   <= done_evt_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    // Busy summary straight from the registered status codes.
    always_comb begin
        any_busy = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++)
            any_busy = any_busy | (status[i] == 2'b01);
    end

    assign MS         = status[0];
    assign CS         = status[1];
    assign DS         = status[2];
    assign done_pulse = done_pulse_q;
endmodule

// File: tb/tb_stage_status_responder.sv
// Scoreboard bench for stage_status_responder: the driver pushes the
// hand-computed response for each cycle, the monitor pops and compares.
module tb_stage_status_responder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] state = 2'b00;
    logic [2:0] fault_in = 3'b000;
    logic [1:0] MS, CS, DS;
    logic       done_pulse, any_busy;

    typedef struct packed {
        logic [1:0] ms;
        logic [1:0] cs;
        logic [1:0] ds;
        logic       dp;
        logic       ab;
    } exp_t;

    exp_t exp_q[$];
    int   id_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step  = 0;

    stage_status_responder dut (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .fault_in   (fault_in),
        .MS         (MS),
        .CS         (CS),
        .DS         (DS),
        .done_pulse (done_pulse),
        .any_busy   (any_busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t actual();
        exp_t a;
        a.ms = MS; a.cs = CS; a.ds = DS; a.dp = done_pulse; a.ab = any_busy;
        return a;
    endfunction

    task automatic check(input string name, input int id, input exp_t a, input exp_t e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s #%0d: got MS=%b CS=%b DS=%b dp=%b busy=%b, want MS=%b CS=%b DS=%b dp=%b busy=%b",
                     name, id, a.ms, a.cs, a.ds, a.dp, a.ab, e.ms, e.cs, e.ds, e.dp, e.ab);
        end
    endtask

    // Drive one cycle of inputs and queue the response expected after the next edge.
    task automatic cyc(input logic [1:0] st, input logic [2:0] f,
                       input logic [1:0] ems, input logic [1:0] ecs,
                       input logic [1:0] eds, input logic edp);
        exp_t e;
        @(negedge clk);
        state    = st;
        fault_in = f;
        e.ms = ems; e.cs = ecs; e.ds = eds; e.dp = edp;
        e.ab = (ems == 2'b01) || (ecs == 2'b01) || (eds == 2'b01);
        step++;
        exp_q.push_back(e);
        id_q.push_back(step);
    endtask

    // Monitor: registered outputs are compared just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            int   id;
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            check("cycle", id, actual(), e);
        end
    end

    initial begin
        exp_t z;
        z = '0;

        // Reset held for two clocks.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", 0, actual(), z);
        rst = 1'b0;

        // Nominal M phase: 3 BUSY, DONE, pulse one clock later.
        cyc(2'b01, 3'b000, 2'b01, 2'b00, 2'b00, 1'b0);
        cyc(2'b01, 3'b000, 2'b01, 2'b00, 2'b00, 1'b0);
        cyc(2'b01, 3'b000, 2'b01, 2'b00, 2'b00, 1'b0);
        cyc(2'b01, 3'b000, 2'b10, 2'b00, 2'b00, 1'b0);
        cyc(2'b01, 3'b000, 2'b10, 2'b00, 2'b00, 1'b1);
        cyc(2'b01, 3'b000, 2'b10, 2'b00, 2'b00, 1'b0);

        // Full sequence: C for 6 clocks, then D for 2.
        cyc(2'b10, 3'b000, 2'b00, 2'b01, 2'b00, 1'b0);
        repeat (5) cyc(2'b10, 3'b000, 2'b00, 2'b01, 2'b00, 1'b0);
        cyc(2'b10, 3'b000, 2'b00, 2'b10, 2'b00, 1'b0);
        cyc(2'b10, 3'b000, 2'b00, 2'b10, 2'b00, 1'b1);
        cyc(2'b11, 3'b000, 2'b00, 2'b00, 2'b01, 1'b0);
        cyc(2'b11, 3'b000, 2'b00, 2'b00, 2'b01, 1'b0);
        cyc(2'b11, 3'b000, 2'b00, 2'b00, 2'b10, 1'b0);
        cyc(2'b11, 3'b000, 2'b00, 2'b00, 2'b10, 1'b1);
        cyc(2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0);

        // Abort C after 3 BUSY clocks, then re-enter for the full 6.
        repeat (3) cyc(2'b10, 3'b000, 2'b00, 2'b01, 2'b00, 1'b0);
        cyc(2'b01, 3'b000, 2'b01, 2'b00, 2'b00, 1'b0);
        cyc(2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0);
        repeat (6) cyc(2'b10, 3'b000, 2'b00, 2'b01, 2'b00, 1'b0);
        cyc(2'b10, 3'b000, 2'b00, 2'b10, 2'b00, 1'b0);
        cyc(2'b10, 3'b000, 2'b00, 2'b10, 2'b00, 1'b1);
        cyc(2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0);

        // Fault on D's last BUSY clock wins over completion and is sticky.
        cyc(2'b11, 3'b000, 2'b00, 2'b00, 2'b01, 1'b0);
        cyc(2'b11, 3'b000, 2'b00, 2'b00, 2'b01, 1'b0);
        cyc(2'b11, 3'b100, 2'b00, 2'b00, 2'b11, 1'b0);
        cyc(2'b01, 3'b000, 2'b01, 2'b00, 2'b11, 1'b0);
        cyc(2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0);

        // Fault ignored once M is DONE.
        repeat (3) cyc(2'b01, 3'b000, 2'b01, 2'b00, 2'b00, 1'b0);
        cyc(2'b01, 3'b000, 2'b10, 2'b00, 2'b00, 1'b0);
        cyc(2'b01, 3'b001, 2'b10, 2'b00, 2'b00, 1'b1);
        cyc(2'b01, 3'b001, 2'b10, 2'b00, 2'b00, 1'b0);
        cyc(2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0);

        // Asynchronous reset mid-BUSY clears outputs before the next edge.
        cyc(2'b10, 3'b000, 2'b00, 2'b01, 2'b00, 1'b0);
        cyc(2'b10, 3'b000, 2'b00, 2'b01, 2'b00, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst", 0, actual(), z);
        @(negedge clk);
        rst = 1'b0;
        repeat (7) cyc(2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0);

        // Drain the scoreboard within a bounded number of clocks.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/stage_status_responder.md
Name: stage_status_responder

Overview:
- Responder side of the controller status interface.
- Consumes the 2-bit controller `state` and, for each of three stages (M, C, D), runs a cycle-count work emulation.
- Drives back the 2-bit status codes MS, CS and DS that the controller sequences on.
- Used as the stage-side model in system benches and as the real stage sequencer for fixed-latency stages.

Parameters:
- M_CYCLES, 3, BUSY duration of the M stage in clocks (legal range 1..2^CNT_W-1)
- C_CYCLES, 6, BUSY duration of the C stage in clocks (legal range 1..2^CNT_W-1)
- D_CYCLES, 2, BUSY duration of the D stage in clocks (legal range 1..2^CNT_W-1)
- CNT_W, 4, width of each per-stage cycle counter

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  reset, asynchronous, active-high
- state  input  2  controller state: 00 IDLE, 01 M phase, 10 C phase, 11 D phase
- fault_in  input  3  per-stage fault injection: bit0 M, bit1 C, bit2 D
- MS  output  2  M-stage status
- CS  output  2  C-stage status
- DS  output  2  D-stage status
- done_pulse  output  1  one-clock pulse when any stage enters DONE
- any_busy  output  1  combinational OR of (status==BUSY) over the three stages

Behaviour:
- One clock; rst is asynchronous and active-high.
- Status encoding, identical for MS/CS/DS: 00 IDLE, 01 BUSY, 10 DONE, 11 FAULT.
- Reset (rst=1, asynchronous):
  - MS=CS=DS=00, all counters 0, done_pulse=0.
  - rst asserted mid-BUSY aborts immediately; no DONE is produced.
- Stage FSMs: three identical FSMs, each with its own phase code (M=01, C=10, D=11) and cycle count N. All transitions occur on the rising clk edge using the sampled `state`.
- IDLE:
  - state==phase: go to BUSY, cnt<=0.
  - Otherwise stay IDLE.
- BUSY:
  - Priority 1: state==00 gives IDLE.
  - Priority 2: fault_in[stage]=1 gives FAULT.
  - Priority 3: state!=phase (abort) gives IDLE, cnt<=0.
  - Priority 4: cnt==N-1 gives DONE.
  - Otherwise cnt<=cnt+1.
  - BUSY is therefore visible for exactly N clocks when undisturbed. N=1 gives a single BUSY cycle.
- DONE:
  - Held while state==phase; fault_in is ignored in DONE.
  - state!=phase gives IDLE.
- FAULT:
  - Sticky; changing to another nonzero phase does not clear it.
  - Cleared only by state==00 (to IDLE) or by rst.
- Latency: status changes one clock after the edge at which `state` is sampled. Status outputs are registered.
- done_pulse: registered; high for exactly one clock, on the cycle after any stage transitions BUSY->DONE. Only one stage can be in phase at a time, so at most one source exists.
- Re-entry: leaving a phase and returning restarts that stage from BUSY with cnt=0. No partial-progress memory.
- Counter never wraps: it stops at N-1. N values outside the legal range are illegal, and behaviour with them is undefined.
- Unused `state` glitches between edges have no effect; the block is purely edge-sampled.

Test Plan:
- Reset then idle: rst=1 for 2 clocks, state=00 -> MS=CS=DS=00, done_pulse=0, any_busy=0; async assert mid-cycle clears outputs before next edge.
- Nominal M phase: state=01 from edge k -> MS=01 for edges k+1..k+3, MS=10 from edge k+4, done_pulse high exactly one clock at k+5; CS=DS=00 throughout.
- Full sequence: state 01, then 10 after MS=10, then 11 after CS=10 -> CS BUSY 6 clocks then DONE, DS BUSY 2 clocks then DONE, MS returns to 00 one clock after state leaves 01, three done_pulses total.
- Abort: state=10, switch to 01 after 3 BUSY clocks -> CS returns to 00 with no DONE and no done_pulse; re-enter 10 later -> CS BUSY full 6 clocks again.
- Fault: state=11, fault_in=3'b100 on second BUSY clock -> DS=11; state changes to 01 -> DS stays 11; state=00 -> DS=00 next clock.
- Fault ignored in DONE, and reset mid-BUSY: fault_in[0]=1 while MS=10 -> MS stays 10; rst pulse during CS=01 -> CS=00 immediately, no done_pulse afterwards.
